sh4a_issue: RTL
===============

# sh4a_issue

In-order issue controller that sits between `sh4a_decode` and the execution units (ALU, multiplier, store unit). It accepts one decoded instruction per cycle, holds it back on register hazards or a busy unit, and routes it onto a single registered issue bus. It keeps a 64-entry register scoreboard and sequences illegal or privileged instruction faults.

## Interface

- `MUL_LATENCY`, 4: cycles from multiplier issue to MACL result (≥2).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `dec_valid`  in  1  decode slot occupied (front-end).
- `dec_ready`  out  1  slot accepted this cycle (combinational).
- `dec_insn_valid`  in  1  decoder `insn_valid`.
- `dec_privileged`  in  1  decoder `insn_privileged`.
- `dec_src1_valid`, `dec_src2_valid`, `dec_dest_valid`, `dec_imm_valid`  in  1 each.
- `dec_src1_reg`, `dec_src2_reg`, `dec_dest_reg`  in  6 each.
- `dec_imm`  in  32.
- `dec_op`  in  6  opcode per `sh4a_op.vh`.
- `priv_mode`  in  1  CPU is in privileged mode.
- `lsu_ready`  in  1  store unit can take a store this cycle.
- `wb_valid`  in  1  ALU writeback.
- `wb_reg`  in  6  register being written back.
- `iss_valid`  out  1  issue bus valid (one-cycle pulse per instruction).
- `iss_unit`  out  2  0 = ALU, 1 = MUL, 2 = LSU.
- `iss_op`  out  6.
- `iss_src1`, `iss_src2`, `iss_dest`  out  6 each.
- `iss_dest_valid`  out  1.
- `iss_imm`  out  32.
- `mul_done`  out  1  one-cycle pulse: MACL result written.
- `exc_valid`  out  1  fault pending.
- `exc_code`  out  2  01 = illegal, 10 = privilege violation.
- `exc_ack`  in  1  fault handler acknowledges.

## Operation

- **States:** RUN, DRAIN, FAULT. Reset enters RUN.
- **Scoreboard:** `busy[63:0]`.
  - Issue sets `busy[dest]` when `dec_dest_valid`. MULTIPLY sets `busy[REG_MACL]`.
  - `REG_CONST_0` and `REG_CONST_1` are never set busy.
  - `wb_valid` clears `busy[wb_reg]`.
- **Unit class:** from `dec_op`.
  - MULTIPLY goes to MUL.
  - STORE8/16/32 go to LSU.
  - All other ops go to ALU.
- **Hazard** (read from the registered `busy`, no bypass): stall if any of:
  - `src1_valid` and `busy[src1]`;
  - `src2_valid` and `busy[src2]`;
  - `dest_valid` and `busy[dest]`;
  - MULTIPLY and `busy[REG_MACL]`.
- **Unit availability:**
  - MUL needs `mul_count == 0`.
  - LSU needs `lsu_ready`.
  - ALU is always available.
- **`dec_ready` in RUN:**
  - For a legal, permitted instruction: no hazard and unit available.
  - For a faulting slot: 1 unconditionally.
  - `dec_ready = 0` in DRAIN and FAULT.
- **Fault detection:**
  - `dec_valid && !dec_insn_valid` → illegal.
  - `dec_insn_valid && dec_privileged && !priv_mode` → privilege violation.
  - Illegal takes precedence.
  - A faulting slot is accepted but never issued. `exc_code` is latched and the state moves to DRAIN.
- **DRAIN:** when `busy == 0` and `mul_count == 0`, go to FAULT and set `exc_valid = 1`.
- **FAULT:** hold `exc_valid` and `exc_code` until `exc_ack`. Then go to RUN; `exc_valid` is 0 from the next cycle.
- **Multiplier counter:**
  - Loaded with `MUL_LATENCY` on MUL issue, then decrements each cycle.
  - On the 1→0 step: pulse `mul_done` and clear `busy[REG_MACL]`.
- **Simultaneous clear and stall:** a `wb_valid` clear of a register that the current slot depends on does not release the slot until the next cycle.

## Timing

- **Reset values:**
  - `busy = 0`, `mul_count = 0`, state RUN.
  - `iss_valid`, `mul_done`, `exc_valid` = 0; `exc_code` = 0.
  - All `iss_*` fields = 0.
- Accept in cycle N (`dec_valid && dec_ready`) → `iss_*` registered, `iss_valid = 1` in cycle N+1. `iss_valid` is 0 in any cycle with no accept.
- Scoreboard set is visible to the slot in cycle N+1. Back-to-back dependent instructions therefore stall at least until the writeback.
- `mul_done` asserts `MUL_LATENCY` cycles after the MUL `iss_valid` cycle.
- Asynchronous reset mid-DRAIN or mid-FAULT returns to RUN with the scoreboard cleared. Any in-flight multiply is abandoned (no `mul_done`).
- `dec_ready` depends only on `dec_*`, `priv_mode`, `lsu_ready` and registered state, with no path from `iss_*`.

## Test plan

- **Independent ADD stream:** `add r1,r2`, then `add r3,r4` back to back → both accepted in consecutive cycles; `iss_valid` high two cycles with `iss_unit = 0`, `iss_dest` 1 then 3.
- **RAW hazard:** `add r1,r2` then `and r1,r5` → second slot stalls (`dec_ready = 0`) until `wb_valid` with `wb_reg = 1`, and is accepted the cycle after.
- **Multiply sequencing:** `mul.l r2,r3` then `sts MACL,r4` with `MUL_LATENCY = 4` → `sts` stalls; `mul_done` pulses 4 cycles after the MUL issue; `sts` is accepted the following cycle.
- **Store backpressure:** `mov.l r1,@r2` with `lsu_ready = 0` for 3 cycles → no accept; accepted in the first cycle `lsu_ready = 1`, with `iss_unit = 2` and `iss_dest_valid = 0`.
- **Illegal and privilege faults:**
  - Illegal slot while the r7 writeback is outstanding → DRAIN until `wb_reg = 7`, then `exc_valid = 1` with `exc_code = 01`; `exc_ack` → RUN.
  - `dec_privileged = 1` with `priv_mode = 0` → `exc_code = 10`.
- **Reset mid-multiply:** assert `reset` 2 cycles after MUL issue → `busy = 0`, no `mul_done`, and the next instruction is accepted immediately after reset deasserts.

Source files
------------

// File: rtl/sh4a_issue.sv
// In-order issue stage: 64-entry register scoreboard, execution-unit routing onto one
// registered issue bus, and illegal/privileged fault sequencing (RUN -> DRAIN -> FAULT).
module sh4a_issue #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic        dec_insn_valid,
  input  logic        dec_privileged,
  input  logic        dec_src1_valid,
  input  logic        dec_src2_valid,
  input  logic        dec_dest_valid,
  input  logic        dec_imm_valid,
  input  logic [5:0]  dec_src1_reg,
  input  logic [5:0]  dec_src2_reg,
  input  logic [5:0]  dec_dest_reg,
  input  logic [31:0] dec_imm,
  input  logic [5:0]  dec_op,
  input  logic        priv_mode,
  input  logic        lsu_ready,
  input  logic        wb_valid,
  input  logic [5:0]  wb_reg,
  output logic        iss_valid,
  output logic [1:0]  iss_unit,
  output logic [5:0]  iss_op,
  output logic [5:0]  iss_src1,
  output logic [5:0]  iss_src2,
  output logic [5:0]  iss_dest,
  output logic        iss_dest_valid,
  output logic [31:0] iss_imm,
  output logic        mul_done,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  input  logic        exc_ack
);

  localparam logic [5:0] REG_MACL    = 6'd17;
  localparam logic [5:0] REG_CONST_0 = 6'd62;
  localparam logic [5:0] REG_CONST_1 = 6'd63;
  localparam logic [5:0] OP_MULTIPLY = 6'd12;
  localparam logic [5:0] OP_STORE8   = 6'd20;
  localparam logic [5:0] OP_STORE16  = 6'd21;
  localparam logic [5:0] OP_STORE32  = 6'd22;
  localparam logic [1:0] UNIT_ALU    = 2'd0;
  localparam logic [1:0] UNIT_MUL    = 2'd1;
  localparam logic [1:0] UNIT_LSU    = 2'd2;
  localparam int unsigned CntW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {StRun, StDrain, StFault} state_e;

  state_e          state_q, state_d;
  logic [63:0]     busy_q, busy_d;
  logic [CntW-1:0] mul_count_q, mul_count_d;
  logic [1:0]      exc_code_q, exc_code_d;
  logic [1:0]      unit;
  logic            is_mul, illegal, priv_fault, fault, hazard, unit_avail, accept, mul_start;

  always_comb begin
    case (dec_op)
      OP_MULTIPLY:                       unit = UNIT_MUL;
      OP_STORE8, OP_STORE16, OP_STORE32: unit = UNIT_LSU;
      default:                           unit = UNIT_ALU;
    endcase
  end

  assign is_mul     = (unit == UNIT_MUL);
  assign illegal    = dec_valid && !dec_insn_valid;
  assign priv_fault = dec_valid && dec_insn_valid && dec_privileged && !priv_mode;
  assign fault      = illegal || priv_fault;

  // Hazards read only the registered scoreboard; a same-cycle writeback does not bypass.
  assign hazard = (dec_src1_valid && busy_q[dec_src1_reg]) ||
                  (dec_src2_valid && busy_q[dec_src2_reg]) ||
                  (dec_dest_valid && busy_q[dec_dest_reg]) ||
                  (is_mul && busy_q[REG_MACL]);

  always_comb begin
    case (unit)
      UNIT_MUL: unit_avail = (mul_count_q == '0);
      UNIT_LSU: unit_avail = lsu_ready;
      default:  unit_avail = 1'b1;
    endcase
  end

  assign dec_ready = (state_q == StRun) && (fault || (!hazard && unit_avail));
  assign accept    = dec_valid && dec_ready && !fault;

  // The multiply latency counts from the cycle the MUL sits on the issue bus.
  assign mul_start = iss_valid && (iss_unit == UNIT_MUL);
  assign mul_done  = (mul_count_q == CntW'(1));
  assign exc_valid = (state_q == StFault);
  assign exc_code  = exc_code_q;

  always_comb begin
    mul_count_d = mul_count_q;
    if (mul_start) begin
      mul_count_d = CntW'(MUL_LATENCY);
    end else if (mul_count_q != '0) begin
      mul_count_d = mul_count_q - CntW'(1);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_reg] = 1'b0;
    if (mul_done) busy_d[REG_MACL] = 1'b0;
    if (accept && dec_dest_valid) busy_d[dec_dest_reg] = 1'b1;
    if (accept && is_mul) busy_d[REG_MACL] = 1'b1;
    busy_d[REG_CONST_0] = 1'b0;
    busy_d[REG_CONST_1] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    exc_code_d = exc_code_q;
    case (state_q)
      StRun: begin
        if (fault) begin
          state_d    = StDrain;
          exc_code_d = illegal ? 2'b01 : 2'b10;
        end
      end
      StDrain: begin
        if (busy_q == '0 && mul_count_q == '0) state_d = StFault;
      end
      StFault: begin
        if (exc_ack) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StRun;
      busy_q         <= '0;
      mul_count_q    <= '0;
      exc_code_q     <= 2'b00;
      iss_valid      <= 1'b0;
      iss_unit       <= '0;
      iss_op         <= '0;
      iss_src1       <= '0;
      iss_src2       <= '0;
      iss_dest       <= '0;
      iss_dest_valid <= 1'b0;
      iss_imm        <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      mul_count_q <= mul_count_d;
      exc_code_q  <= exc_code_d;
      iss_valid   <= accept;
      if (accept) begin
        iss_unit       <= unit;
        iss_op         <= dec_op;
        iss_src1       <= dec_src1_reg;
        iss_src2       <= dec_src2_reg;
        iss_dest       <= dec_dest_reg;
        iss_dest_valid <= dec_dest_valid;
        iss_imm        <= dec_imm_valid ? dec_imm : 32'h0;
      end
    end
  end

endmodule
